dbus_responder: RTL and testbench

Memory-side responder for the core's data bus: it services the load/store requests that the control unit raises on `dbus_re`/`dbus_we` during execute. It holds a word-organised data RAM, inserts a configurable number of wait states, and drives `stall` back to the control unit so that the core's state machine freezes until the access completes. It performs byte/half/word lane selection, sign/zero extension on reads, and byte-lane merging on writes. The access size is the instruction's f3 field.

---
 rtl/dbus_responder.sv | 209 ++++++++++++++++++++
 tb/tb_dbus_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// Data-bus responder: word RAM with wait states, lane select/extend on loads, byte-lane merge on stores.
// Optional misalignment fault reporting is enabled by defining DBUS_MISALIGN_FAULT_EN.
module dbus_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_wdata,
  input  logic [2:0]  dbus_size,
  input  logic        dbus_re,
  input  logic        dbus_we,
  output logic [31:0] dbus_rdata,
  output logic        stall,
`ifdef DBUS_MISALIGN_FAULT_EN
  output logic        dbus_fault,
`endif
  output logic        dbus_done
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic [IDX_W+1:0]   addr_r;
  logic [31:0]        wdata_r;
  logic [2:0]         size_r;
  logic               we_r;
  logic [31:0]        rdata_r;
  logic               done_r;
  logic [31:0]        mem_r [MEM_WORDS];

  logic               req_s, enter_done_s, fault_s, wr_ok_s;
  logic [IDX_W+1:0]   cur_addr_s;
  logic [2:0]         cur_size_s;
  logic               cur_we_s;
  logic [31:0]        rd_word_s;
  logic [3:0]         wr_be_s;
  logic [31:0]        wr_data_s;
  logic               unused_s;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] size);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size[1:0])
      2'd0:    load_extend = size[2] ? {24'h000000, b} : {{24{b[7]}}, b};
      2'd1:    load_extend = size[2] ? {16'h0000, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] size);
    case (size[1:0])
      2'd0:    store_be = 4'b0001 << lane;
      2'd1:    store_be = lane[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [2:0] size);
    case (size[1:0])
      2'd0:    store_data = {4{wdata[7:0]}};
      2'd1:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  assign req_s    = dbus_re | dbus_we;
  assign unused_s = ^dbus_addr[31:IDX_W+2];

  // Access attributes: live inputs on the accepting cycle, latched copies afterwards.
  always_comb begin
    if (state_r == IDLE) begin
      cur_addr_s = dbus_addr[IDX_W+1:0];
      cur_size_s = dbus_size;
      cur_we_s   = dbus_we;
    end else begin
      cur_addr_s = addr_r;
      cur_size_s = size_r;
      cur_we_s   = we_r;
    end
  end

  // Next-state and wait counter; with no wait states BUSY is skipped so only the request cycle stalls.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          cnt_s   = 4'(WAIT_STATES);
          state_s = (WAIT_STATES == 0) ? DONE : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        cnt_s = (cnt_r == 4'd0) ? 4'd0 : cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = HOLD;
      HOLD: begin
        if (req_s) begin
          state_s = HOLD;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign enter_done_s = (state_s == DONE) && (state_r != DONE);
  assign rd_word_s    = mem_r[cur_addr_s[IDX_W+1:2]];
  assign wr_be_s      = store_be(addr_r[1:0], size_r);
  assign wr_data_s    = store_data(wdata_r, size_r);

`ifdef DBUS_MISALIGN_FAULT_EN
  logic fault_r;

  function automatic logic is_misaligned(input logic [1:0] lane, input logic [2:0] size);
    case (size[1:0])
      2'd1:    is_misaligned = lane[0];
      2'd2:    is_misaligned = |lane;
      2'd3:    is_misaligned = |lane;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  assign fault_s = is_misaligned(cur_addr_s[1:0], cur_size_s);

  // Fault pulse coincides with the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= enter_done_s & fault_s;
    end
  end

  assign dbus_fault = fault_r;
  assign wr_ok_s    = ~fault_r;
`else
  assign fault_s = 1'b0;
  assign wr_ok_s = 1'b1;
`endif

  // Control state, latched request and registered load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= 32'h0;
      size_r  <= 3'd0;
      we_r    <= 1'b0;
      rdata_r <= 32'h0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      done_r  <= enter_done_s;
      if (state_r == IDLE && req_s) begin
        addr_r  <= dbus_addr[IDX_W+1:0];
        wdata_r <= dbus_wdata;
        size_r  <= dbus_size;
        we_r    <= dbus_we;
      end
      if (enter_done_s) begin
        if (fault_s) begin
          rdata_r <= 32'h0;
        end else if (!cur_we_s) begin
          rdata_r <= load_extend(rd_word_s, cur_addr_s[1:0], cur_size_s);
        end
      end
    end
  end

  // Single RAM write on the edge leaving DONE; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_r == DONE && we_r && wr_ok_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_s[i]) begin
          mem_r[addr_r[IDX_W+1:2]][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

  assign stall      = rst & (((state_r == IDLE) & req_s) | (state_r == BUSY));
  assign dbus_done  = done_r;
  assign dbus_rdata = rdata_r;

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized scoreboard bench for dbus_responder against a byte-array memory model.
module tb_dbus_responder;

  localparam int WS = 2;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [2:0]  dbus_size;
  logic        dbus_re, dbus_we, stall, dbus_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem_b [0:4*MW-1];
  logic [31:0] m_rdata;
  logic [31:0] exp_q [$];

  dbus_responder #(.MEM_WORDS(MW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_size(dbus_size), .dbus_re(dbus_re), .dbus_we(dbus_we),
    .dbus_rdata(dbus_rdata), .stall(stall), .dbus_done(dbus_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    if (sz[1:0] == 2'd0) return 1;
    if (sz[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int base_of(input logic [31:0] a, input logic [2:0] sz);
    int b;
    b = int'(a % (4 * MW));
    return b - (b % nbytes(sz));
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] v;
    int n, b;
    n = nbytes(sz);
    b = base_of(a, sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v + (32'(mem_b[b+i]) << (8 * i));
    if (!sz[2] && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    int n, b;
    n = nbytes(sz);
    b = base_of(a, sz);
    for (int i = 0; i < n; i++) mem_b[b+i] = 8'(d >> (8 * i));
  endtask

  // One complete request/response handshake; expected load data goes to the scoreboard.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz, input int hold);
    int n;
    if (w) begin
      m_store(a, d, sz);
    end else begin
      m_rdata = m_load(a, sz);
    end
    exp_q.push_back(m_rdata);
    @(negedge clk);
    dbus_we = w; dbus_re = r; dbus_addr = a; dbus_wdata = d; dbus_size = sz;
    #1;
    n = 0;
    while (stall && n < 40) begin
      n++;
      @(negedge clk); #1;
      if (w) dbus_wdata = $urandom();
    end
    check("stall_len", 32'(n), 32'(WS + 1));
    check("done_pulse", 32'(dbus_done), 32'd1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      dbus_wdata = $urandom();
      check("hold_nodone", 32'(dbus_done), 32'd0);
      check("hold_nostall", 32'(stall), 32'd0);
    end
    @(negedge clk);
    dbus_re = 1'b0; dbus_we = 1'b0;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst === 1'b1 && dbus_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got a done pulse, expected none");
      end else begin
        check("rdata", dbus_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] old, a;
    int k;
    rst = 1'b0; dbus_re = 1'b0; dbus_we = 1'b0;
    dbus_addr = 32'h0; dbus_wdata = 32'h0; dbus_size = 3'd0;
    m_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(dbus_done), 32'd0);
    check("rst_rdata", dbus_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 192; i++) access(1'b1, 1'b0, 32'(i * 4), $urandom(), 3'd2, 0);

    access(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 3'd2, 0);
    access(1'b0, 1'b1, 32'h100, 32'h0, 3'd2, 0);
    check("word_rt", dbus_rdata, 32'hDEADBEEF);

    access(1'b1, 1'b0, 32'h100, 32'h0, 3'd2, 0);
    access(1'b1, 1'b0, 32'h103, 32'h80, 3'd0, 0);
    access(1'b0, 1'b1, 32'h103, 32'h0, 3'd0, 0);
    check("byte_signed", dbus_rdata, 32'hFFFFFF80);
    access(1'b0, 1'b1, 32'h103, 32'h0, 3'd4, 0);
    check("byte_unsigned", dbus_rdata, 32'h00000080);
    access(1'b0, 1'b1, 32'h100, 32'h0, 3'd2, 0);
    check("byte_merge", dbus_rdata, 32'h80000000);

    access(1'b1, 1'b0, 32'h104, 32'hA5A51234, 3'd2, 8);
    access(1'b0, 1'b1, 32'h104, 32'h0, 3'd2, 0);
    check("held_we_once", dbus_rdata, 32'hA5A51234);

    access(1'b1, 1'b1, 32'h0, 32'h12345678, 3'd2, 0);
    check("both_keep", dbus_rdata, 32'hA5A51234);
    access(1'b0, 1'b1, 32'h0, 32'h0, 3'd2, 0);
    check("both_write", dbus_rdata, 32'h12345678);

    access(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, 3'd2, 0);
    access(1'b0, 1'b1, 32'h0, 32'h0, 3'd2, 0);
    check("alias", dbus_rdata, 32'hCAFEF00D);

    access(1'b1, 1'b0, 32'h102, 32'h0BADC0DE, 3'd2, 0);
    access(1'b0, 1'b1, 32'h100, 32'h0, 3'd2, 0);
    check("misalign_word", dbus_rdata, 32'h0BADC0DE);

    old = m_load(32'h200, 3'd2);
    @(negedge clk);
    dbus_we = 1'b1; dbus_addr = 32'h200; dbus_wdata = ~old; dbus_size = 3'd2;
    @(negedge clk);
    rst = 1'b0; dbus_we = 1'b0;
    #1;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_rdata", dbus_rdata, 32'h0);
    m_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 1'b1, 32'h200, 32'h0, 3'd2, 0);
    check("midrst_nowrite", dbus_rdata, old);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 767));
      k = $urandom_range(0, 2);
      access(k != 0, k != 1, a, $urandom(), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
